// File: rtl/index_address_unit.sv
// ---------------------------------------------------------------------------
// index_address_unit
// Indexed effective-address generator for a 6502-style core. It collects a
// one- or two-byte base operand from the data bus, adds the latched X/Y
// index and produces a 16-bit effective address. In zero-page mode the result
// wraps within page 0.
//
// Optional feature macro: PAGE_CROSS_PENALTY_EN
//   defined   : absolute accesses that carry into the high byte, and all
//               absolute writes, spend one extra FIXUP cycle before DONE.
//   undefined : no FIXUP cycle; the high byte is corrected directly in ADD.
// ---------------------------------------------------------------------------
module index_address_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        zp_mode,
    input  logic        write_op,
    input  logic [7:0]  index_in,
    input  logic [7:0]  db_in,
    input  logic        db_valid,
    output logic [15:0] ea_out,
    output logic        ea_valid,
    output logic        page_cross,
    output logic        fixup_cycle,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_LO,
        FETCH_HI,
        ADD,
        FIXUP,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic        r_zpMode;
    logic        r_writeOp;
    logic [7:0]  r_index;
    logic [7:0]  r_baseLo;
    logic [7:0]  r_baseHi;
    logic [15:0] r_eaOut;
    logic        r_pageCross;

    logic [8:0]  w_sum;
    logic        w_carry;
    logic [15:0] w_eaValue;
    logic        w_pcValue;
    logic        w_loadEa;

    // Low-byte add and the final address; operands come only from latched
    // copies, so late changes on the inputs cannot leak into the result.
    assign w_sum     = {1'b0, r_baseLo} + {1'b0, r_index};
    assign w_carry   = w_sum[8];
    assign w_eaValue = r_zpMode ? {8'h00, w_sum[7:0]}
                                : {r_baseHi + {7'b0000000, w_carry}, w_sum[7:0]};
    assign w_pcValue = ~r_zpMode & w_carry;

    // Next-state decode and the strobe that commits the address registers.
    always_comb begin
        w_nextState = r_state;
        w_loadEa    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = FETCH_LO;
                end
            end
            FETCH_LO: begin
                if (db_valid) begin
                    w_nextState = r_zpMode ? ADD : FETCH_HI;
                end
            end
            FETCH_HI: begin
                if (db_valid) begin
                    w_nextState = ADD;
                end
            end
            ADD: begin
`ifdef PAGE_CROSS_PENALTY_EN
                if (!r_zpMode && (w_carry || r_writeOp)) begin
                    w_nextState = FIXUP;
                end else begin
                    w_nextState = DONE;
                    w_loadEa    = 1'b1;
                end
`else
                w_nextState = DONE;
                w_loadEa    = 1'b1;
`endif
            end
            FIXUP: begin
                w_nextState = DONE;
                w_loadEa    = 1'b1;
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register, operand latches and result registers; reset wins over
    // everything so an aborted operation leaves no trace and no pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_zpMode    <= 1'b0;
            r_writeOp   <= 1'b0;
            r_index     <= 8'h00;
            r_baseLo    <= 8'h00;
            r_baseHi    <= 8'h00;
            r_eaOut     <= 16'h0000;
            r_pageCross <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && start) begin
                r_zpMode  <= zp_mode;
                r_writeOp <= write_op;
                r_index   <= index_in;
            end
            if (r_state == FETCH_LO && db_valid) begin
                r_baseLo <= db_in;
            end
            if (r_state == FETCH_HI && db_valid) begin
                r_baseHi <= db_in;
            end
            if (w_loadEa) begin
                r_eaOut     <= w_eaValue;
                r_pageCross <= w_pcValue;
            end
        end
    end

`ifdef PAGE_CROSS_PENALTY_EN
    assign fixup_cycle = (r_state == FIXUP);
`else
    logic w_unused;
    assign w_unused    = r_writeOp;
    assign fixup_cycle = 1'b0;
`endif

    assign ea_out     = r_eaOut;
    assign page_cross = r_pageCross;
    assign ea_valid   = (r_state == DONE);
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_index_address_unit.sv
// ---------------------------------------------------------------------------
// tb_index_address_unit
// Directed bench for index_address_unit. Expected addresses, flags and
// latencies are hand-computed constants; latencies depend on whether
// PAGE_CROSS_PENALTY_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_index_address_unit;

`ifdef PAGE_CROSS_PENALTY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        zp_mode;
    logic        write_op;
    logic [7:0]  index_in;
    logic [7:0]  db_in;
    logic        db_valid;
    logic [15:0] ea_out;
    logic        ea_valid;
    logic        page_cross;
    logic        fixup_cycle;
    logic        busy;

    int checkCount;
    int errorCount;
    int cyc;

    index_address_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .zp_mode    (zp_mode),
        .write_op   (write_op),
        .index_in   (index_in),
        .db_in      (db_in),
        .db_valid   (db_valid),
        .ea_out     (ea_out),
        .ea_valid   (ea_valid),
        .page_cross (page_cross),
        .fixup_cycle(fixup_cycle),
        .busy       (busy)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and log a miss.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Run one full address computation. Cycle 0 is the cycle in which start
    // is presented; the cycle where ea_valid is seen is compared to expCyc.
    // expFix is the cycle in which fixup_cycle should be high (0 = never).
    task automatic applyStimulus(input string tag, input logic zp, input logic wr,
                                 input logic [7:0] idx, input logic [7:0] lo,
                                 input logic [7:0] hi, input int loStall,
                                 input int hiStall, input logic perturb,
                                 input logic [15:0] expEa, input logic expPc,
                                 input int expCyc, input int expFix);
        int validCyc;
        int fixCyc;
        logic [15:0] gotEa;
        logic gotPc;
        validCyc = 0;
        fixCyc   = 0;
        gotEa    = 16'hxxxx;
        gotPc    = 1'bx;
        cyc      = 0;
        start    = 1'b1;
        zp_mode  = zp;
        write_op = wr;
        index_in = idx;
        db_valid = 1'b0;
        db_in    = 8'hAA;
        step();
        start = 1'b0;
        if (perturb) begin
            index_in = ~idx;
            zp_mode  = ~zp;
            write_op = ~wr;
        end
        checkOutput({tag, ".busy"}, {31'b0, busy}, 32'd1);
        repeat (loStall) begin
            db_valid = 1'b0;
            db_in    = 8'h5A;
            step();
        end
        db_valid = 1'b1;
        db_in    = lo;
        step();
        if (!zp) begin
            repeat (hiStall) begin
                db_valid = 1'b0;
                db_in    = 8'hC3;
                step();
            end
            db_valid = 1'b1;
            db_in    = hi;
            step();
        end
        db_valid = 1'b0;
        db_in    = 8'h00;
        for (int i = 0; i < 12; i++) begin
            if (fixup_cycle && fixCyc == 0) fixCyc = cyc;
            if (ea_valid) begin
                validCyc = cyc;
                gotEa    = ea_out;
                gotPc    = page_cross;
                break;
            end
            step();
        end
        checkOutput({tag, ".latency"}, validCyc, expCyc);
        checkOutput({tag, ".fixup"}, fixCyc, expFix);
        checkOutput({tag, ".ea_out"}, {16'b0, gotEa}, {16'b0, expEa});
        checkOutput({tag, ".page_cross"}, {31'b0, gotPc}, {31'b0, expPc});
        step();
        checkOutput({tag, ".pulse"}, {31'b0, ea_valid}, 32'd0);
        checkOutput({tag, ".idle"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, ".hold"}, {16'b0, ea_out}, {16'b0, expEa});
    endtask

    initial begin
        int pulses;
        checkCount = 0;
        errorCount = 0;
        cyc        = 0;
        reset      = 1'b1;
        start      = 1'b0;
        zp_mode    = 1'b0;
        write_op   = 1'b0;
        index_in   = 8'h00;
        db_in      = 8'h00;
        db_valid   = 1'b0;
        repeat (2) step();
        reset = 1'b0;

        checkOutput("rst.ea_out", {16'b0, ea_out}, 32'h0000);
        checkOutput("rst.ea_valid", {31'b0, ea_valid}, 32'd0);
        checkOutput("rst.page_cross", {31'b0, page_cross}, 32'd0);
        checkOutput("rst.fixup", {31'b0, fixup_cycle}, 32'd0);
        checkOutput("rst.busy", {31'b0, busy}, 32'd0);
        step();

        applyStimulus("absNoCarry", 1'b0, 1'b0, 8'h10, 8'h34, 8'h12, 0, 0, 1'b0,
                      16'h1244, 1'b0, 4, 0);
        applyStimulus("absCarry", 1'b0, 1'b0, 8'h20, 8'hF0, 8'h12, 0, 0, 1'b0,
                      16'h1310, 1'b1, 4 + PEN, PEN * 4);
        applyStimulus("zpWrap", 1'b1, 1'b0, 8'h20, 8'hF0, 8'h77, 0, 0, 1'b0,
                      16'h0010, 1'b0, 3, 0);
        applyStimulus("topWrap", 1'b0, 1'b1, 8'h01, 8'hFF, 8'hFF, 0, 0, 1'b0,
                      16'h0000, 1'b1, 4 + PEN, PEN * 4);
        applyStimulus("writePen", 1'b0, 1'b1, 8'h05, 8'h00, 8'h10, 0, 0, 1'b0,
                      16'h1005, 1'b0, 4 + PEN, PEN * 4);
        applyStimulus("stall", 1'b0, 1'b0, 8'h10, 8'h34, 8'h12, 2, 1, 1'b1,
                      16'h1244, 1'b0, 7, 0);

        // Abort an absolute operation while it waits in FETCH_HI.
        cyc      = 0;
        start    = 1'b1;
        zp_mode  = 1'b0;
        write_op = 1'b0;
        index_in = 8'h22;
        step();
        start    = 1'b0;
        db_valid = 1'b1;
        db_in    = 8'h40;
        step();
        db_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("abort.busy", {31'b0, busy}, 32'd0);
        checkOutput("abort.ea_out", {16'b0, ea_out}, 32'h0000);
        checkOutput("abort.page_cross", {31'b0, page_cross}, 32'd0);
        pulses   = 0;
        db_valid = 1'b1;
        db_in    = 8'h99;
        repeat (6) begin
            if (ea_valid) pulses++;
            step();
        end
        db_valid = 1'b0;
        checkOutput("abort.noPulse", pulses, 0);

        applyStimulus("afterAbort", 1'b1, 1'b0, 8'h05, 8'h80, 8'h00, 0, 0, 1'b0,
                      16'h0085, 1'b0, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
